four_bit_bcd_sync_par_counter: RTL and testbench

//  - Synchronous (parallel-clocked) 4-bit BCD decade counter, 0..9, wraps to 0.
//  - All flip-flops share one clock; next state is decoded in parallel, with no ripple.
//  - carry and clrnout let several decades cascade into multi-digit BCD counters.
//  - Used as a digit stage in counter/timer datapaths.

---
 rtl/four_bit_bcd_sync_par_counter_if.sv | 24 ++
 rtl/four_bit_bcd_sync_par_counter.sv | 52 +++++
 tb/tb_four_bit_bcd_sync_par_counter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/four_bit_bcd_sync_par_counter_if.sv
// Control/status bundle for one BCD decade counter stage.
// BCD_CNTR_LOAD_EN adds the parallel-load pair (load, din).
interface four_bit_bcd_sync_par_counter_if;
  logic       cnt_en;
`ifdef BCD_CNTR_LOAD_EN
  logic       load;
  logic [3:0] din;
`endif
  logic [3:0] count;
  logic       carry;
  logic       clrnout;

`ifdef BCD_CNTR_LOAD_EN
  modport master (output cnt_en, output load, output din,
                  input  count, input carry, input clrnout);
  modport slave  (input  cnt_en, input  load, input  din,
                  output count, output carry, output clrnout);
`else
  modport master (output cnt_en,
                  input  count, input carry, input clrnout);
  modport slave  (input  cnt_en,
                  output count, output carry, output clrnout);
`endif
endinterface

// File: rtl/four_bit_bcd_sync_par_counter.sv
// Synchronous 4-bit BCD decade counter (0..9) with cascade carry/clrnout.
// BCD_CNTR_LOAD_EN enables a synchronous parallel load that takes priority over counting.
module four_bit_bcd_sync_par_counter (
  input  logic                            i_rst,
  input  logic                            i_clk,
  four_bit_bcd_sync_par_counter_if.slave  bus
);

  localparam logic [3:0] LP_MAX = 4'd9;

  logic [3:0] r_count;
  logic [3:0] w_count_nxt;
  logic [3:0] w_count_inc;
  logic       w_at_max;
  logic       w_legal;
  logic       w_carry;

  assign w_at_max    = (r_count == LP_MAX);
  assign w_legal     = (r_count <= LP_MAX);
  assign w_count_inc = r_count + 4'd1;

  // Any count outside 0..9 collapses to 0 on the next enabled edge.
  always_comb begin
    w_count_nxt = r_count;
`ifdef BCD_CNTR_LOAD_EN
    if (bus.load) begin
      w_count_nxt = (bus.din <= LP_MAX) ? bus.din : 4'd0;
    end else if (bus.cnt_en) begin
      w_count_nxt = (w_at_max || !w_legal) ? 4'd0 : w_count_inc;
    end
`else
    if (bus.cnt_en) begin
      w_count_nxt = (w_at_max || !w_legal) ? 4'd0 : w_count_inc;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 4'd0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  // Pure decode so a downstream stage sees the enable in the same cycle.
  assign w_carry     = bus.cnt_en & w_at_max;
  assign bus.count   = r_count;
  assign bus.carry   = w_carry;
  assign bus.clrnout = ~w_carry;

endmodule

// File: tb/tb_four_bit_bcd_sync_par_counter.sv
// Directed, table-driven bench for the BCD decade counter, plus a two-digit cascade.
module tb_four_bit_bcd_sync_par_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  four_bit_bcd_sync_par_counter_if if_a ();
  four_bit_bcd_sync_par_counter_if if_lo ();
  four_bit_bcd_sync_par_counter_if if_hi ();

  four_bit_bcd_sync_par_counter u_dut (.i_rst(rst), .i_clk(clk), .bus(if_a.slave));
  four_bit_bcd_sync_par_counter u_lo  (.i_rst(rst), .i_clk(clk), .bus(if_lo.slave));
  four_bit_bcd_sync_par_counter u_hi  (.i_rst(rst), .i_clk(clk), .bus(if_hi.slave));

  assign if_hi.cnt_en = if_lo.carry;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] cnt;
    logic       car;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input int c, input logic k);
    vec_t v;
    v.rst = r; v.en = e; v.cnt = 4'(c); v.car = k;
    vecs.push_back(v);
  endtask

  task automatic check_a(input string tag, input int c, input logic k);
    chk({tag, " count"},   if_a.count,          4'(c));
    chk({tag, " carry"},   {3'b0, if_a.carry},   {3'b0, k});
    chk({tag, " clrnout"}, {3'b0, if_a.clrnout}, {3'b0, ~k});
  endtask

  initial begin
    rst = 1'b1;
    if_a.cnt_en  = 1'b0;
    if_lo.cnt_en = 1'b0;
`ifdef BCD_CNTR_LOAD_EN
    if_a.load = 1'b0;  if_a.din = 4'd0;
    if_lo.load = 1'b0; if_lo.din = 4'd0;
    if_hi.load = 1'b0; if_hi.din = 4'd0;
`endif

    // reset with cnt_en high
    add(1, 1, 0, 0);
    add(1, 1, 0, 0);
    // count 12 edges
    for (int i = 1; i <= 12; i++) add(0, 1, i % 10, (i % 10) == 9);
    // up to 5, then hold 3 edges
    add(0, 1, 3, 0); add(0, 1, 4, 0); add(0, 1, 5, 0);
    add(0, 0, 5, 0); add(0, 0, 5, 0); add(0, 0, 5, 0);
    // mid-run reset at 7
    add(0, 1, 6, 0); add(0, 1, 7, 0);
    add(1, 1, 0, 0);
    add(0, 1, 1, 0); add(0, 1, 2, 0);
    // run to 9, hold at 9 with enable low, then wrap
    for (int i = 3; i <= 9; i++) add(0, 1, i, i == 9);
    add(0, 0, 9, 0);
    add(0, 0, 9, 0);
    add(0, 1, 0, 0);
    add(0, 1, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      if_a.cnt_en = vecs[i].en;
      @(posedge clk);
      #1;
      check_a($sformatf("vec%0d", i), int'(vecs[i].cnt), vecs[i].car);
    end

    // carry is combinational on cnt_en: drop enable at count 1 -> still 0; at 9 test below
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if_a.cnt_en = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("reach9 count", if_a.count, 4'd9);
    chk("reach9 carry", {3'b0, if_a.carry}, 4'd1);
    if_a.cnt_en = 1'b0;
    #1;
    chk("en_drop carry",   {3'b0, if_a.carry},   4'd0);
    chk("en_drop clrnout", {3'b0, if_a.clrnout}, 4'd1);

`ifdef BCD_CNTR_LOAD_EN
    @(negedge clk);
    rst = 1'b0; if_a.cnt_en = 1'b0; if_a.load = 1'b1; if_a.din = 4'd8;
    @(posedge clk); #1;
    check_a("load8", 8, 0);
    @(negedge clk);
    if_a.load = 1'b0; if_a.cnt_en = 1'b1;
    @(posedge clk); #1;
    check_a("load8+1", 9, 1);
    @(posedge clk); #1;
    check_a("load8+2", 0, 0);
    @(negedge clk);
    if_a.load = 1'b1; if_a.din = 4'd12; if_a.cnt_en = 1'b1;
    @(posedge clk); #1;
    check_a("load12", 0, 0);
    @(negedge clk);
    if_a.din = 4'd3;
    @(posedge clk); #1;
    check_a("load_beats_en", 3, 0);
    @(negedge clk);
    rst = 1'b1; if_a.din = 4'd6;
    @(posedge clk); #1;
    check_a("rst_beats_load", 0, 0);
    @(negedge clk);
    rst = 1'b0; if_a.load = 1'b0; if_a.cnt_en = 1'b0;
`endif

    // two-digit cascade
    @(negedge clk);
    rst = 1'b1; if_lo.cnt_en = 1'b1;
    @(posedge clk); #1;
    chk("casc rst lo", if_lo.count, 4'd0);
    chk("casc rst hi", if_hi.count, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      chk($sformatf("casc%0d lo", k), if_lo.count, 4'((k % 10)));
      chk($sformatf("casc%0d hi", k), if_hi.count, 4'(((k / 10) % 10)));
    end
    chk("casc lo carry after 100", {3'b0, if_lo.carry}, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
